// File: rtl/regfile_pkg.sv
// Shared types and helpers for regfile_mp and its scoreboard.
// Optional same-cycle write bypass is enabled with the REGFILE_BYPASS_EN macro.
package regfile_pkg;

    localparam int DEF_XLEN = 32;
    localparam int DEF_NREG = 32;

    // Upper bound on write ports handled by the priority resolver.
    localparam int MAX_WP   = 32;
    localparam int WP_IDX_W = 5;

    typedef enum logic [0:0] {
        CLR_IDLE  = 1'b0,
        CLR_SWEEP = 1'b1
    } clr_state_t;

    typedef struct packed {
        logic                hit;
        logic [WP_IDX_W-1:0] port;
    } wr_sel_t;

    // hits[p] is set when write port p targets the address of interest;
    // the highest-indexed hitting port wins.
    function automatic wr_sel_t wr_winner(input logic [MAX_WP-1:0] hits);
        wr_sel_t sel;
        sel = '0;
        for (int p = 0; p < MAX_WP; p++) begin
            if (hits[p]) begin
                sel.hit  = 1'b1;
                sel.port = WP_IDX_W'(p);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, set on issue,
// cleared on writeback, flushed all at once by the soft-clear engine.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREG = DEF_NREG,
    parameter int NWP  = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_flush,
    input  logic                          i_issue_en,
    input  logic [$clog2(NREG)-1:0]       i_issue_addr,
    input  logic [NWP-1:0]                i_wr_en,
    input  logic [NWP*$clog2(NREG)-1:0]   i_wr_addr,
    output logic [NREG-1:0]               o_busy
);

    localparam int AW = $clog2(NREG);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Issue is applied after the write clears so it wins on a shared address.
    always_comb begin
        busy_d = busy_q;
        for (int p = 0; p < NWP; p++) begin
            if (i_wr_en[p]) begin
                busy_d[i_wr_addr[p*AW +: AW]] = 1'b0;
            end
        end
        if (i_issue_en) begin
            busy_d[i_issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            busy_q <= '0;
        end else if (i_flush) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign o_busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with pending-write scoreboard and a
// sequenced soft-clear engine. Define REGFILE_BYPASS_EN for same-cycle bypass.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN = DEF_XLEN,
    parameter int NREG = DEF_NREG,
    parameter int NRP  = 2,
    parameter int NWP  = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NRP*$clog2(NREG)-1:0]   i_rs_addr,
    output logic [NRP*XLEN-1:0]           o_rs_data,
    output logic [NRP-1:0]                o_rs_busy,
    input  logic [NWP-1:0]                i_wr_en,
    input  logic [NWP*$clog2(NREG)-1:0]   i_wr_addr,
    input  logic [NWP*XLEN-1:0]           i_wr_data,
    input  logic                          i_issue_en,
    input  logic [$clog2(NREG)-1:0]       i_issue_addr,
    input  logic                          i_clr,
    output logic                          o_clr_busy,
    output clr_state_t                    o_clr_state
);

    localparam int AW = $clog2(NREG);

    clr_state_t      clr_state, clr_state_d;
    logic [AW-1:0]   clr_cnt, clr_cnt_d;
    logic            sb_flush;
    logic            sweep;

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] sb_busy;

    logic [AW-1:0]   wr_addr [NWP];
    logic [XLEN-1:0] wr_data [NWP];
    logic [NWP-1:0]  wr_en_ok;
    logic            issue_ok;

    logic [NREG-1:0] reg_we;
    logic [XLEN-1:0] reg_wd [NREG];

    assign sweep    = (clr_state == CLR_SWEEP);
    assign issue_ok = i_issue_en && !sweep && (i_issue_addr != '0);

    for (genvar p = 0; p < NWP; p++) begin : g_wport
        assign wr_addr[p]  = i_wr_addr[p*AW +: AW];
        assign wr_data[p]  = i_wr_data[p*XLEN +: XLEN];
        assign wr_en_ok[p] = i_wr_en[p] && !sweep && (wr_addr[p] != '0);
    end

    // Resolved write per register; also the bypass source for reads.
    for (genvar r = 0; r < NREG; r++) begin : g_wsel
        logic [MAX_WP-1:0] hits;
        wr_sel_t           sel;
        logic [XLEN-1:0]   wd;
        always_comb begin
            hits = '0;
            for (int p = 0; p < NWP; p++) begin
                hits[p] = wr_en_ok[p] && (wr_addr[p] == AW'(r));
            end
            sel = wr_winner(hits);
            wd  = '0;
            for (int p = 0; p < NWP; p++) begin
                if (sel.port == WP_IDX_W'(p)) begin
                    wd = wr_data[p];
                end
            end
        end
        assign reg_we[r] = sel.hit;
        assign reg_wd[r] = wd;
    end

    // i_clr is a level request taken only in CLR_IDLE; o_clr_busy acknowledges
    // by staying high for the whole sweep, during which all traffic is dropped.
    always_comb begin
        clr_state_d = clr_state;
        clr_cnt_d   = clr_cnt;
        sb_flush    = 1'b0;
        case (clr_state)
            CLR_IDLE: begin
                if (i_clr) begin
                    clr_state_d = CLR_SWEEP;
                    clr_cnt_d   = AW'(1);
                    sb_flush    = 1'b1;
                end
            end
            CLR_SWEEP: begin
                clr_cnt_d = clr_cnt + 1'b1;
                if (clr_cnt == AW'(NREG - 1)) begin
                    clr_state_d = CLR_IDLE;
                    clr_cnt_d   = '0;
                end
            end
            default: clr_state_d = CLR_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            clr_state <= CLR_IDLE;
            clr_cnt   <= '0;
        end else begin
            clr_state <= clr_state_d;
            clr_cnt   <= clr_cnt_d;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else if (sweep) begin
            regs[clr_cnt] <= '0;
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (reg_we[r]) begin
                    regs[r] <= reg_wd[r];
                end
            end
        end
    end

    regfile_scoreboard #(
        .NREG (NREG),
        .NWP  (NWP)
    ) u_scoreboard (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_flush      (sb_flush),
        .i_issue_en   (issue_ok),
        .i_issue_addr (i_issue_addr),
        .i_wr_en      (wr_en_ok),
        .i_wr_addr    (i_wr_addr),
        .o_busy       (sb_busy)
    );

    for (genvar k = 0; k < NRP; k++) begin : g_rport
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;
        logic            rb;
        assign ra = i_rs_addr[k*AW +: AW];
        always_comb begin
            rd = '0;
            rb = 1'b0;
            if (!sweep && (ra != '0)) begin
                rd = regs[ra];
                rb = sb_busy[ra];
`ifdef REGFILE_BYPASS_EN
                if (reg_we[ra]) begin
                    rd = reg_wd[ra];
                    if (!(issue_ok && (i_issue_addr == ra))) begin
                        rb = 1'b0;
                    end
                end
`endif
            end
        end
        assign o_rs_data[k*XLEN +: XLEN] = rd;
        assign o_rs_busy[k]              = rb;
    end

    assign o_clr_busy  = sweep;
    assign o_clr_state = clr_state;

endmodule
